// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit for the 5-stage core: forwarding, load-use stalls, PC-write flushes,
// a latency sequencer for multi-cycle execute ops, and saturating stall/flush counters.
module hazard_unit_mc #(
  parameter int REG_AW = 4,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] RA1D,
  input  logic [REG_AW-1:0] RA2D,
  input  logic [REG_AW-1:0] RA1E,
  input  logic [REG_AW-1:0] RA2E,
  input  logic [REG_AW-1:0] WA3E,
  input  logic [REG_AW-1:0] WA3M,
  input  logic [REG_AW-1:0] WA3W,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              BranchTakenE,
  input  logic              PCSrcD,
  input  logic              PCSrcE,
  input  logic              PCSrcM,
  input  logic              PCSrcW,
  input  logic              MultiCycleE,
  input  logic              CntClr,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              McBusy,
  output logic              McDone,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  if (MC_LAT < 2 || MC_LAT > 255) begin : g_bad_lat
    $error("hazard_unit_mc: MC_LAT must lie in 2..255");
  end

  typedef enum logic {IDLE, BUSY} mc_state_e;

  localparam logic [7:0] McInit = 8'(MC_LAT - 2);

  mc_state_e        state_q;
  logic [7:0]       cnt_q;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;
  logic             ldrStall;
  logic             pcWrPend;
  logic             mcStall;

  // M-stage result is younger than W, so it wins when both match.
  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (RA1E == WA3M))      ForwardAE = 2'b10;
    else if (RegWriteW && (RA1E == WA3W)) ForwardAE = 2'b01;
    ForwardBE = 2'b00;
    if (RegWriteM && (RA2E == WA3M))      ForwardBE = 2'b10;
    else if (RegWriteW && (RA2E == WA3W)) ForwardBE = 2'b01;
  end

  assign ldrStall = MemtoRegE && RegWriteE && ((RA1D == WA3E) || (RA2D == WA3E));
  assign pcWrPend = PCSrcD || PCSrcE || PCSrcM;
  assign mcStall  = ((state_q == IDLE) && MultiCycleE && !BranchTakenE)
                 || ((state_q == BUSY) && (cnt_q != 8'd0));

  // A frozen E stage must keep its op, so flushes yield to the multi-cycle stall.
  assign StallF = ldrStall || pcWrPend || mcStall;
  assign StallD = ldrStall || mcStall;
  assign StallE = mcStall;
  assign FlushD = (pcWrPend || PCSrcW || BranchTakenE) && !mcStall;
  assign FlushE = (ldrStall || BranchTakenE) && !mcStall;
  assign FlushM = mcStall;
  assign McBusy = mcStall;
  assign McDone = (state_q == BUSY) && (cnt_q == 8'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (MultiCycleE && !BranchTakenE) begin
            state_q <= BUSY;
            cnt_q   <= McInit;
          end
        end
        BUSY: begin
          if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
          else               state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (CntClr) begin
      stallCnt_d = '0;
      flushCnt_d = '0;
    end else begin
      if (StallF && (stallCnt_q != '1)) stallCnt_d = stallCnt_q + 1'b1;
      if ((FlushD || FlushE || FlushM) && (flushCnt_q != '1)) flushCnt_d = flushCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign StallCnt = stallCnt_q;
  assign FlushCnt = flushCnt_q;

endmodule
